spi_boot_master: RTL
====================

// Module: spi_boot_master
// PURPOSE
//  Synthesizable SPI/QSPI master that drives pulpino_top's SPI slave port (spi_clk_i, spi_cs_i, spi_sdi*_i)
//  and loads a word stream into memory, replacing bench-driven spi_load for FPGA standalone boot.
//  Optionally switches the slave to QPI first (reg0 write), then issues one memory write burst
//  (cmd 0x02, 32b address, N data words). Sits between a ROM/flash word source and the SoC pads.
// PARAMETERS
//  CLK_DIV   2   sck half-period in clk cycles (>=1); sck freq = f_clk/(2*CLK_DIV)
//  CNT_W     16  width of word counter; max burst 2**CNT_W-1 words
//  USE_QSPI  1   1: enable QPI then send cmd/addr/data on 4 lanes; 0: single lane (sdo0) throughout
// PORTS
//  clk           in   1      system clock
//  rst           in   1      asynchronous reset, active-high
//  start_i       in   1      one-cycle pulse, begin transfer (ignored while busy_o)
//  addr_i        in   32     target byte address, sampled on start_i
//  nwords_i      in   CNT_W  number of 32b words, sampled on start_i
//  data_i        in   32     next data word
//  data_valid_i  in   1      data_i valid
//  data_ready_o  out  1      word accepted when data_valid_i & data_ready_o
//  busy_o        out  1      transfer in progress
//  done_o        out  1      one-cycle pulse when burst complete and csn deasserted
//  spi_sck_o     out  1      SPI clock, idle low (mode 0)
//  spi_csn_o     out  1      chip select, active low
//  spi_sdo_o     out  4      data lanes; [0] is single-lane line, [3] nibble MSB in quad
// BEHAVIOUR
//  Reset: spi_csn_o=1, spi_sck_o=0, spi_sdo_o=0, busy_o=0, done_o=0, data_ready_o=0, FSM=IDLE.
//  Reset mid-transfer aborts immediately (async); no partial frame recovery.
//  FSM: IDLE -> [USE_QSPI] QPI_EN -> GAP -> CMD -> ADDR -> DATA -> FINISH -> IDLE.
//   QPI_EN: csn low, single lane, 16 bits: 0x01 (write reg0) then 0x01 (QPI enable).
//   GAP: csn high for 2*CLK_DIV clk cycles between frames.
//   CMD: 8b 0x02; ADDR: 32b addr; DATA: 32b per word. Quad when USE_QSPI: 4 bits/sck, sdo[3]=MSB.
//   FINISH: sck low, csn high for CLK_DIV cycles, then done_o pulse, busy_o falls same cycle.
//  Bit order MSB first. Lanes change only while sck low; slave samples on sck rising edge.
//  First bit valid when csn falls; first sck rising edge CLK_DIV cycles later.
//  sck generated by a divider counter 0..CLK_DIV-1 toggling sck at terminal count; counter
//   held at 0 when not shifting (sck static low).
//  data_ready_o high for one word-slot: from entering DATA (or last bit of previous word shifted)
//   until handshake. Word loaded into shifter on handshake cycle.
//  Underflow: if no valid word at a word boundary, sck holds low, csn stays low, lanes hold;
//   shifting resumes on next handshake (no timing penalty beyond stall).
//  Word counter loaded with nwords_i, decremented per accepted word; DATA exits after
//   last word's final bit and its falling edge.
//  nwords_i==0: no SPI traffic, done_o pulses 2 cycles after start_i, busy_o high for 1 cycle.
//  start_i while busy_o: ignored, latched addr/nwords unchanged.
//  QPI_EN is sent on every start (idempotent for slave).
// STRUCTURE
//  Package spi_boot_pkg: state enum (IDLE,QPI_EN,GAP,CMD,ADDR,DATA,FINISH), constants
//   CMD_WR_REG0=8'h01, QPI_EN_VAL=8'h01, CMD_WR_MEM=8'h02, bit-length constants.
//  Sub-module spi_boot_shifter: 32b shift reg, bit counter, sck divider, single/quad select;
//   load/len/quad inputs, frame_done output. Top holds FSM, word counter, handshake.
// TESTING
//  Bench uses pulpino spi slave model / pulpino_top, CLK_DIV=2, USE_QSPI=1.
//  1) start addr=0x0000_0000, nwords=4, data 0x11111111.. -> QPI_EN frame of 16 sck on sdo0, csn
//     high 4 clks, then 2+8+32 quad sck; memory reads back 4 words; one done_o pulse.
//  2) USE_QSPI=0, addr=0x0010_0000, nwords=1, data=0xDEADBEEF -> 72 sck single-lane, mem word correct.
//  3) data_valid_i low 50 clks mid-burst -> sck/sdo frozen, csn low, data still intact after resume.
//  4) nwords=0 -> csn never falls, done_o 2 cycles after start, busy_o 1 cycle.
//  5) rst asserted mid-ADDR -> csn=1, sck=0 same cycle; new start after release completes normally.
//  6) start_i pulsed during DATA with different addr -> ignored; single done_o, original addr written.

Source files
------------

// File: rtl/spi_boot_pkg.sv
// rtl/spi_boot_pkg.sv - shared states and frame constants for the SPI boot master
package spi_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QPI_EN,
        GAP,
        CMD,
        ADDR,
        DATA,
        FINISH
    } state_t;

    localparam logic [7:0] CMD_WR_REG0 = 8'h01;
    localparam logic [7:0] QPI_EN_VAL  = 8'h01;
    localparam logic [7:0] CMD_WR_MEM  = 8'h02;

    localparam logic [5:0] LEN_QPI_EN = 6'd16;
    localparam logic [5:0] LEN_CMD    = 6'd8;
    localparam logic [5:0] LEN_WORD   = 6'd32;

endpackage

// File: rtl/spi_boot_shifter.sv
// rtl/spi_boot_shifter.sv - MSB-first frame shifter with sck divider, single or quad lanes
module spi_boot_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic [5:0]  i_len,
    input  logic        i_quad,
    output logic        o_frame_done,
    output logic        o_active,
    output logic        o_sck,
    output logic [3:0]  o_sdo
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [31:0]      r_shift;
    logic [5:0]       r_left;
    logic             r_quad;
    logic             r_active;
    logic             r_sck;
    logic [DIV_W-1:0] r_div;

    logic       w_tc;
    logic       w_fall;
    logic [5:0] w_step;

    assign w_tc         = (r_div == DIV_LAST);
    assign w_fall       = r_active & w_tc & r_sck;
    assign w_step       = r_quad ? 6'd4 : 6'd1;
    assign o_frame_done = w_fall & (r_left == w_step);

    // The last bit is not shifted out, so lanes hold steady across word stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_left   <= '0;
            r_quad   <= 1'b0;
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_div    <= '0;
        end else if (i_load) begin
            r_shift  <= i_data;
            r_left   <= i_len;
            r_quad   <= i_quad;
            r_active <= 1'b1;
            r_sck    <= 1'b0;
            r_div    <= '0;
        end else if (r_active) begin
            if (w_tc) begin
                r_div <= '0;
                r_sck <= ~r_sck;
                if (r_sck) begin
                    if (o_frame_done) begin
                        r_active <= 1'b0;
                    end else begin
                        r_shift <= r_quad ? {r_shift[27:0], 4'h0} : {r_shift[30:0], 1'b0};
                        r_left  <= r_left - w_step;
                    end
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_active = r_active;
    assign o_sck    = r_sck;
    assign o_sdo    = r_quad ? r_shift[31:28] : {3'b000, r_shift[31]};

endmodule

// File: rtl/spi_boot_master.sv
// rtl/spi_boot_master.sv - boot loader: optional QPI enable, then one memory write burst
module spi_boot_master
    import spi_boot_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 16,
    parameter bit USE_QSPI = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      addr_i,
    input  logic [CNT_W-1:0] nwords_i,
    input  logic [31:0]      data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             spi_sck_o,
    output logic             spi_csn_o,
    output logic [3:0]       spi_sdo_o
);

    localparam int CNT_BITS = $clog2(2 * CLK_DIV + 1);
    localparam logic [CNT_BITS-1:0] GAP_LAST = CNT_BITS'(2 * CLK_DIV - 1);
    localparam logic [CNT_BITS-1:0] FIN_LAST = CNT_BITS'(CLK_DIV - 1);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_addr;
    logic [CNT_W-1:0]    r_words;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_csn;
    logic                r_done;

    logic        w_load;
    logic [31:0] w_ld_data;
    logic [5:0]  w_ld_len;
    logic        w_ld_quad;
    logic        w_frame_done;
    logic        w_shift_active;
    logic        w_ready;

    // Next word may be taken while idle or on the very edge the current word finishes.
    assign w_ready = (r_state == DATA) && (r_words != '0) && (!w_shift_active || w_frame_done);

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_ld_data = '0;
        w_ld_len  = '0;
        w_ld_quad = 1'b0;
        case (r_state)
            IDLE: if (start_i) begin
                if (nwords_i == '0) begin
                    w_next = FINISH;
                end else if (USE_QSPI) begin
                    w_next    = QPI_EN;
                    w_load    = 1'b1;
                    w_ld_data = {CMD_WR_REG0, QPI_EN_VAL, 16'h0000};
                    w_ld_len  = LEN_QPI_EN;
                end else begin
                    w_next    = CMD;
                    w_load    = 1'b1;
                    w_ld_data = {CMD_WR_MEM, 24'h000000};
                    w_ld_len  = LEN_CMD;
                end
            end
            QPI_EN: if (w_frame_done) w_next = GAP;
            GAP: if (r_cnt == GAP_LAST) begin
                w_next    = CMD;
                w_load    = 1'b1;
                w_ld_data = {CMD_WR_MEM, 24'h000000};
                w_ld_len  = LEN_CMD;
                w_ld_quad = USE_QSPI;
            end
            CMD: if (w_frame_done) begin
                w_next    = ADDR;
                w_load    = 1'b1;
                w_ld_data = r_addr;
                w_ld_len  = LEN_WORD;
                w_ld_quad = USE_QSPI;
            end
            ADDR: if (w_frame_done) w_next = DATA;
            DATA: begin
                if (w_ready && data_valid_i) begin
                    w_load    = 1'b1;
                    w_ld_data = data_i;
                    w_ld_len  = LEN_WORD;
                    w_ld_quad = USE_QSPI;
                end else if (w_frame_done && r_words == '0) begin
                    w_next = FINISH;
                end
            end
            FINISH: if (r_cnt == FIN_LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_words <= '0;
            r_cnt   <= '0;
            r_csn   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == FINISH) && (w_next == IDLE);
            r_csn   <= !(w_next inside {QPI_EN, CMD, ADDR, DATA});
            // An empty burst enters FINISH pre-counted so busy lasts a single cycle.
            if (w_next != r_state) begin
                r_cnt <= (r_state == IDLE && w_next == FINISH) ? FIN_LAST : '0;
            end else if (r_state == GAP || r_state == FINISH) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
            if (r_state == IDLE && start_i) begin
                r_addr  <= addr_i;
                r_words <= nwords_i;
            end else if (w_ready && data_valid_i) begin
                r_words <= r_words - CNT_W'(1);
            end
        end
    end

    spi_boot_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_data       (w_ld_data),
        .i_len        (w_ld_len),
        .i_quad       (w_ld_quad),
        .o_frame_done (w_frame_done),
        .o_active     (w_shift_active),
        .o_sck        (spi_sck_o),
        .o_sdo        (spi_sdo_o)
    );

    assign data_ready_o = w_ready;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;
    assign spi_csn_o    = r_csn;

endmodule
